// File: rtl/apb_pkg.sv
// Shared APB4 types: requester FSM states, pprot attribute masks and the latched command record.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  localparam logic [2:0] PROT_PRIV   = 3'b001;
  localparam logic [2:0] PROT_NONSEC = 3'b010;
  localparam logic [2:0] PROT_INSTR  = 3'b100;

  // Widest address/data the command record carries; the requester's parameters must not exceed these.
  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_W-1:0]     addr;
    logic [APB_DATA_W-1:0]     wdata;
    logic [APB_DATA_W/8-1:0]   strb;
    logic [2:0]                prot;
  } apb_cmd_t;

endpackage

// File: rtl/apb4_master.sv
// APB4 requester: turns a valid/ready command stream into single APB4 transfers and returns
// read data / error / timeout status on a valid/ready response channel.
module apb4_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   paddr,
  output logic [2:0]          pprot,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr
);

  localparam int unsigned    CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  apb_state_e          state_q, state_d;
  apb_cmd_t            cmd_q, cmd_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic                psel_q, penable_q, rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                wait_hit;

  assign wait_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

  // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || wait_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture, wait counting and response capture. pready/prdata/pslverr matter only in ACCESS.
  always_comb begin
    cmd_d         = cmd_q;
    wait_d        = wait_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d.write = cmd_write;
          cmd_d.addr  = APB_ADDR_W'(cmd_addr);
          cmd_d.wdata = cmd_wdata;
          cmd_d.strb  = cmd_write ? cmd_strb : '0;
          cmd_d.prot  = cmd_prot;
          wait_d      = '0;
        end
      end
      ACCESS: begin
        if (pready) begin
          rsp_rdata_d   = cmd_q.write ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
        end else if (wait_hit) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (wait_q != '1) begin
          wait_d = wait_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) wait_d = '0;
      end
      default: ;
    endcase
  end

  // Bus and response strobes are registered from the next state so they line up with it.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      wait_q        <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      wait_q        <= wait_d;
      psel_q        <= (state_d == SETUP) || (state_d == ACCESS);
      penable_q     <= (state_d == ACCESS);
      rsp_valid_q   <= (state_d == RESP);
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign paddr       = cmd_q.addr[ADDR_W-1:0];
  assign pprot       = cmd_q.prot;
  assign pwrite      = cmd_q.write;
  assign pwdata      = cmd_q.wdata;
  assign pstrb       = cmd_q.strb;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
